// File: rtl/mem_responder_pkg.sv
// Shared types for the multi-cycle memory responder.
// Holds the FSM state encoding and the latched request bundle.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// imem/dmem request/response bundle between the core and a responder.
// The master issues requests and the slave answers them.
interface mem_responder_if;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_addr,
        output mem_rmask,
        output mem_wmask,
        output mem_wdata,
        input  mem_rdata,
        input  mem_resp
    );

    modport slave (
        input  mem_addr,
        input  mem_rmask,
        input  mem_wmask,
        input  mem_wdata,
        output mem_rdata,
        output mem_resp
    );

endinterface

// File: rtl/mem_responder_array.sv
// DEPTH x 32 word storage with per-byte write enables.
// Synchronous write, combinational read, contents never reset.
module mem_responder_array #(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_idx,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Commit each enabled byte lane on the clock edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory model answering one imem/dmem port.
// Latches a request, waits LATENCY cycles, then pulses mem_resp.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h6000_0000,
    parameter int          LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic            err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t    r_state;
    mem_state_t    w_next;
    mem_req_t      r_req;
    mem_req_t      w_in;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_req;
    logic          w_accept;
    logic          w_done;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_proto;
    logic [31:0]   w_off;
    logic [31:0]   w_rword;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;

    assign w_in = '{
        addr:  bus.mem_addr,
        rmask: bus.mem_rmask,
        wmask: bus.mem_wmask,
        wdata: bus.mem_wdata
    };

    assign w_req = |(bus.mem_rmask | bus.mem_wmask);

    // Below-BASE addresses wrap to a huge offset, so one compare covers both ends.
    assign w_off      = r_req.addr - BASE;
    assign w_in_range = ({1'b0, w_off} < (33'(DEPTH) << 2));
    assign w_misalign = |r_req.addr[1:0];
    assign w_idx      = w_off[AW+1:2];

    assign w_done  = (r_state == BUSY) && (r_cnt == '0);
    assign w_be    = r_req.wmask & {4{w_done && w_in_range}};
    assign w_proto = (r_state == BUSY) && (w_in != r_req);

    mem_responder_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_idx   (w_idx),
        .i_be    (w_be),
        .i_wdata (r_req.wdata),
        .o_rdata (w_rword)
    );

    // Next state, counter load/decrement and request acceptance.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next     = BUSY;
                    w_cnt_next = CW'(LATENCY - 1);
                    w_accept   = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            RESP: begin
                if (w_req) begin
                    w_next     = BUSY;
                    w_cnt_next = CW'(LATENCY - 1);
                    w_accept   = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, latched request, pre-write read word and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_req <= w_in;
            end
            if (w_done) begin
                r_rdata <= w_in_range ? w_rword : '0;
            end
            if (w_proto || (w_done && (!w_in_range || w_misalign))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mem_resp  = (r_state == RESP);
    assign bus.mem_rdata = (r_state == RESP) ? r_rdata : '0;
    assign err           = r_err;

endmodule
